// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Shares one UART transmitter among NUM_REQ requesters.
//               Round-robin grant with packet lock, one-byte holding
//               register, and the UART write/busy handshake sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int DATA_WIDTH    = 8,
    parameter int BUSY_WAIT_MAX = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          uart_we,
    output logic [DATA_WIDTH-1:0]         uart_data,
    input  logic                          uart_busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          locked,
    output logic                          err_no_busy
);

    localparam int c_id_w  = $clog2(NUM_REQ);
    localparam int c_cnt_w = $clog2(BUSY_WAIT_MAX + 1);
    localparam logic [c_id_w-1:0]  c_last_id   = c_id_w'(NUM_REQ - 1);
    localparam logic [c_cnt_w-1:0] c_wait_last = c_cnt_w'(BUSY_WAIT_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [c_id_w-1:0]       r_grant_id;
    logic                    r_locked;
    logic [c_id_w-1:0]       r_rr_ptr;
    logic [c_cnt_w-1:0]      r_wait_cnt;

    logic                    w_found;
    logic [c_id_w-1:0]       w_winner;
    logic [c_id_w-1:0]       w_idx;
    logic                    w_accept;
    logic                    w_we;
    logic                    w_err;
    logic [NUM_REQ-1:0]      w_ready;
    logic [DATA_WIDTH-1:0]   w_win_data;
    logic                    w_win_last;
    logic [c_id_w-1:0]       w_rr_next;

    // Pick the winner: a held lock pins the grant, otherwise rotate from rr pointer
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = c_id_w'((int'(r_rr_ptr) + i) % NUM_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
        if (r_locked) begin
            w_found  = req_valid[r_grant_id];
            w_winner = r_grant_id;
        end
    end

    assign w_win_data = req_data[w_winner*DATA_WIDTH +: DATA_WIDTH];
    assign w_win_last = req_last[w_winner];
    assign w_rr_next  = (w_winner == c_last_id) ? '0 : w_winner + 1'b1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake strobes; accept is suppressed while in reset
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_we        = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found && !rst) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!uart_busy) begin
                    w_we        = 1'b1;
                    w_state_nxt = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (uart_busy) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_wait_cnt == c_wait_last) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (!uart_busy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // One-hot ready for the winner only during an accept
    always_comb begin
        w_ready = '0;
        if (w_accept) begin
            w_ready[w_winner] = 1'b1;
        end
    end

    // Holding register, grant/lock bookkeeping and the busy-rise timeout counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data     <= '0;
            r_grant_id <= '0;
            r_locked   <= 1'b0;
            r_rr_ptr   <= '0;
            r_wait_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_data     <= w_win_data;
                r_grant_id <= w_winner;
                r_locked   <= ~w_win_last;
                if (w_win_last) begin
                    r_rr_ptr <= w_rr_next;
                end
            end
            if (w_we) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_WAIT_BUSY && !uart_busy) begin
                r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
            end
        end
    end

    assign req_ready   = w_ready;
    assign uart_we     = w_we & ~rst;
    assign err_no_busy = w_err & ~rst;
    assign uart_data   = r_data;
    assign grant_id    = r_grant_id;
    assign locked      = r_locked;

endmodule
`default_nettype wire
